// File: rtl/serial_comparator_msb_first_framed_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_comparator_msb_first_framed_if
// Brief   : Digit stream and result bundle for the framed serial comparator.
//           Optional feature macro: SERIAL_CMP_SIGNED_EN (adds signed_cmp).
// Rev     : 1.0
// ============================================================================
interface serial_comparator_msb_first_framed_if #(
  parameter int DIGIT_W = 1
);
  logic               valid;
  logic               first;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
`ifdef SERIAL_CMP_SIGNED_EN
  logic               signed_cmp;
`endif
  logic               res_valid;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;

`ifdef SERIAL_CMP_SIGNED_EN
  modport master (
    output valid, first, a, b, signed_cmp,
    input  res_valid, a_less_b, a_eq_b, a_greater_b
  );
  modport slave (
    input  valid, first, a, b, signed_cmp,
    output res_valid, a_less_b, a_eq_b, a_greater_b
  );
`else
  modport master (
    output valid, first, a, b,
    input  res_valid, a_less_b, a_eq_b, a_greater_b
  );
  modport slave (
    input  valid, first, a, b,
    output res_valid, a_less_b, a_eq_b, a_greater_b
  );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_comparator_msb_first_framed.sv
`default_nettype none
// ============================================================================
// Module  : serial_comparator_msb_first_framed
// Brief   : MSB-first framed serial magnitude comparator, DIGIT_W bits/beat.
//           Optional feature macro: SERIAL_CMP_SIGNED_EN (signed first digit).
// Rev     : 1.0
// ============================================================================
module serial_comparator_msb_first_framed #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  serial_comparator_msb_first_framed_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EQUAL   = 2'd1,
    S_LESS    = 2'd2,
    S_GREATER = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_dig_st;
  state_t             w_decided;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_res_valid;
  logic               r_lt;
  logic               r_eq;
  logic               r_gt;
  logic               w_first_beat;
  logic               w_cont_beat;
  logic               w_done;
  logic               w_dig_gt;
  logic               w_dig_lt;
  logic [DIGIT_W-1:0] w_a;
  logic [DIGIT_W-1:0] w_b;

  assign w_a          = bus.a;
  assign w_b          = bus.b;
  assign w_first_beat = bus.valid & bus.first;
  // Continuation digits are ignored until a first beat has opened a word.
  assign w_cont_beat  = bus.valid & ~bus.first & (r_state != S_IDLE);

  always_comb begin
    w_dig_gt = (w_a > w_b);
    w_dig_lt = (w_a < w_b);
`ifdef SERIAL_CMP_SIGNED_EN
    if (w_first_beat && bus.signed_cmp) begin
      w_dig_gt = ($signed(w_a) > $signed(w_b));
      w_dig_lt = ($signed(w_a) < $signed(w_b));
    end
`endif
    w_dig_st = w_dig_gt ? S_GREATER : (w_dig_lt ? S_LESS : S_EQUAL);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_decided   = r_state;
    w_done      = 1'b0;
    if (w_first_beat) begin
      w_decided = w_dig_st;
      if (NDIG == 1) begin
        w_done = 1'b1;
      end else begin
        w_state_nxt = w_dig_st;
        w_cnt_nxt   = ONE_CNT;
      end
    end else if (w_cont_beat) begin
      w_decided = (r_state == S_EQUAL) ? w_dig_st : r_state;
      if (r_cnt == LAST_CNT) begin
        w_done = 1'b1;
      end else begin
        w_state_nxt = w_decided;
        w_cnt_nxt   = r_cnt + ONE_CNT;
      end
    end
    if (w_done) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b1;
      r_gt        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_res_valid <= w_done;
      if (w_done) begin
        r_lt <= (w_decided == S_LESS);
        r_eq <= (w_decided == S_EQUAL);
        r_gt <= (w_decided == S_GREATER);
      end
    end
  end

`ifdef SERIAL_CMP_SIGNED_EN
  logic r_signed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signed <= 1'b0;
    end else if (w_first_beat) begin
      r_signed <= bus.signed_cmp;
    end
  end
`endif

  assign bus.res_valid   = r_res_valid;
  assign bus.a_less_b    = r_lt;
  assign bus.a_eq_b      = r_eq;
  assign bus.a_greater_b = r_gt;
endmodule
`default_nettype wire

// File: tb/tb_serial_comparator_msb_first_framed.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_comparator_msb_first_framed
// Brief   : Self-checking bench: 8x1 and 16x4 instances, whole-word reference.
// Rev     : 1.0
// ============================================================================
module tb_serial_comparator_msb_first_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses8  = 0;
  int   pulses16 = 0;

  always #5 clk = ~clk;

  serial_comparator_msb_first_framed_if #(.DIGIT_W(1)) if8 ();
  serial_comparator_msb_first_framed_if #(.DIGIT_W(4)) if16 ();

  serial_comparator_msb_first_framed #(.WIDTH(8), .DIGIT_W(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_comparator_msb_first_framed #(.WIDTH(16), .DIGIT_W(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  // Each res_valid-high cycle is counted at the following rising edge.
  always @(posedge clk) begin
    if (if8.res_valid === 1'b1)  pulses8  <= pulses8 + 1;
    if (if16.res_valid === 1'b1) pulses16 <= pulses16 + 1;
  end

  // 0 = A<B, 1 = A==B, 2 = A>B on the whole word value
  function automatic int ref_cmp(input longint a, input longint b, input int w, input bit sgn);
    longint half;
    longint sa;
    longint sb;
    half = longint'(1) << (w - 1);
    sa = (sgn && a >= half) ? a - 2 * half : a;
    sb = (sgn && b >= half) ? b - 2 * half : b;
    if (sa < sb) return 0;
    if (sa == sb) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] exp_bus(input bit rv, input int r);
    return {rv, r == 0, r == 1, r == 2};
  endfunction

  task automatic drv8(input logic v, input logic f, input logic a, input logic b);
    if8.valid = v; if8.first = f; if8.a = a; if8.b = b;
    @(negedge clk);
  endtask

  task automatic drv16(input logic v, input logic f, input logic [3:0] a, input logic [3:0] b);
    if16.valid = v; if16.first = f; if16.a = a; if16.b = b;
    @(negedge clk);
  endtask

  // Stalls are inserted before bit/digit index stall_at (never before the first).
  task automatic send8(input logic [7:0] A, input logic [7:0] B, input int stall_at, input int stalls);
    for (int i = 7; i >= 0; i--) begin
      if (i == stall_at) repeat (stalls) drv8(1'b0, 1'b0, 1'b0, 1'b0);
      drv8(1'b1, i == 7, A[i], B[i]);
    end
    if8.valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] A, input logic [15:0] B, input int stall_at, input int stalls);
    for (int d = 3; d >= 0; d--) begin
      if (d == stall_at) repeat (stalls) drv16(1'b0, 1'b0, 4'h0, 4'h0);
      drv16(1'b1, d == 3, A[4*d +: 4], B[4*d +: 4]);
    end
    if16.valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    repeat (2) @(negedge clk);
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b0010) begin n_fail++; $display("FAIL reset8: got %b expected 0010", got); end
    got = {if16.res_valid, if16.a_less_b, if16.a_eq_b, if16.a_greater_b};
    n_checks++;
    if (got !== 4'b0010) begin n_fail++; $display("FAIL reset16: got %b expected 0010", got); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gt_directed();
    logic [3:0] got;
    int p0;
    p0 = pulses8;
    send8(8'hA5, 8'hA3, -1, 0);
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b1001) begin n_fail++; $display("FAIL gt_a5_a3: got %b expected 1001", got); end
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (if8.res_valid !== 1'b0) begin n_fail++; $display("FAIL gt_pulse_width: res_valid %b expected 0", if8.res_valid); end
    n_checks++;
    if (pulses8 - p0 !== 1) begin n_fail++; $display("FAIL gt_pulse_count: got %0d expected 1", pulses8 - p0); end
  endtask

  task automatic test_equal_stalls();
    logic [3:0] got;
    int p0;
    p0 = pulses8;
    send8(8'h3C, 8'h3C, $urandom_range(0, 6), 3);
    n_checks++;
    if (pulses8 - p0 !== 0) begin n_fail++; $display("FAIL eq_early_pulse: got %0d expected 0", pulses8 - p0); end
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b1010) begin n_fail++; $display("FAIL eq_stalls: got %b expected 1010", got); end
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    logic [3:0] got;
    int p0;
    p0 = pulses8;
    drv8(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) drv8(1'b1, 1'b0, 1'b0, 1'b1);
    send8(8'hFF, 8'h00, -1, 0);
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pulses8 - p0 !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d expected 1", pulses8 - p0); end
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b0001) begin n_fail++; $display("FAIL abort_flags: got %b expected 0001", got); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    int p0;
    p0 = pulses16;
    send16(16'h1234, 16'h1240, -1, 0);
    got = {if16.res_valid, if16.a_less_b, if16.a_eq_b, if16.a_greater_b};
    n_checks++;
    if (got !== 4'b1100) begin n_fail++; $display("FAIL b2b_word1: got %b expected 1100", got); end
    send16(16'hFFFF, 16'hFFFF, -1, 0);
    got = {if16.res_valid, if16.a_less_b, if16.a_eq_b, if16.a_greater_b};
    n_checks++;
    if (got !== 4'b1010) begin n_fail++; $display("FAIL b2b_word2: got %b expected 1010", got); end
    drv16(1'b0, 1'b0, 4'h0, 4'h0);
    n_checks++;
    if (pulses16 - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses16 - p0); end
  endtask

`ifdef SERIAL_CMP_SIGNED_EN
  task automatic test_signed();
    logic [3:0] got;
    if8.signed_cmp = 1'b1;
    send8(8'h80, 8'h01, -1, 0);
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b1100) begin n_fail++; $display("FAIL signed_80_01: got %b expected 1100", got); end
    if8.signed_cmp = 1'b0;
    send8(8'h80, 8'h01, -1, 0);
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b1001) begin n_fail++; $display("FAIL unsigned_80_01: got %b expected 1001", got); end
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      bit          use16;
      int          w;
      int          mode;
      int          p0;
      int          r;
      bit          sgn;
      logic [15:0] A;
      logic [15:0] B;
      logic [3:0]  got;
      use16 = (it % 2) == 1;
      w     = use16 ? 16 : 8;
      mode  = $urandom_range(0, 2);
      sgn   = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
      if8.signed_cmp  = sgn;
      if16.signed_cmp = sgn;
`endif
      A = 16'($urandom);
      B = (mode == 0) ? A : (mode == 1) ? (A ^ (16'd1 << $urandom_range(0, w - 1))) : 16'($urandom);
      if (!use16) begin
        A = A & 16'h00FF;
        B = B & 16'h00FF;
      end
      r = ref_cmp(longint'(A), longint'(B), w, sgn);
      if (use16) begin
        p0 = pulses16;
        send16(A, B, $urandom_range(0, 2), $urandom_range(0, 2));
        got = {if16.res_valid, if16.a_less_b, if16.a_eq_b, if16.a_greater_b};
        n_checks++;
        if (pulses16 - p0 !== 0) begin n_fail++; $display("FAIL rand16_early_pulse: got %0d expected 0", pulses16 - p0); end
        drv16(1'b0, 1'b0, 4'h0, 4'h0);
      end else begin
        p0 = pulses8;
        send8(A[7:0], B[7:0], $urandom_range(0, 6), $urandom_range(0, 2));
        got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
        n_checks++;
        if (pulses8 - p0 !== 0) begin n_fail++; $display("FAIL rand8_early_pulse: got %0d expected 0", pulses8 - p0); end
        drv8(1'b0, 1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (got !== exp_bus(1'b1, r)) begin
        n_fail++;
        $display("FAIL rand_word w=%0d A=%h B=%h sgn=%0d: got %b expected %b", w, A, B, sgn, got, exp_bus(1'b1, r));
      end
    end
`ifdef SERIAL_CMP_SIGNED_EN
    if8.signed_cmp  = 1'b0;
    if16.signed_cmp = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    int p0;
    send8(8'hF0, 8'h00, -1, 0);
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
    drv8(1'b1, 1'b1, 1'b0, 1'b1);
    drv8(1'b1, 1'b0, 1'b0, 1'b1);
    drv8(1'b1, 1'b0, 1'b0, 1'b1);
    if8.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b0010) begin n_fail++; $display("FAIL async_reset: got %b expected 0010", got); end
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses8;
    repeat (8) drv8(1'b1, 1'b0, 1'b1, 1'b0);
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pulses8 - p0 !== 0) begin n_fail++; $display("FAIL post_reset_drop: got %0d pulses expected 0", pulses8 - p0); end
    send8(8'h12, 8'h34, 3, 1);
    got = {if8.res_valid, if8.a_less_b, if8.a_eq_b, if8.a_greater_b};
    n_checks++;
    if (got !== 4'b1100) begin n_fail++; $display("FAIL post_reset_word: got %b expected 1100", got); end
    drv8(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pulses8 - p0 !== 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses8 - p0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if8.valid = 1'b0;  if8.first = 1'b0;  if8.a = '0;  if8.b = '0;
    if16.valid = 1'b0; if16.first = 1'b0; if16.a = '0; if16.b = '0;
`ifdef SERIAL_CMP_SIGNED_EN
    if8.signed_cmp  = 1'b0;
    if16.signed_cmp = 1'b0;
`endif
    test_reset();
    test_gt_directed();
    test_equal_stalls();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_CMP_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
